// File: rtl/normalize_stage_pkg.sv
// Shared types and default widths for the adder normalize stage.
// The packed transfer types are sized by FP_MANT_W / FP_EXP_W.
package fpadd_pkg;

    localparam int FP_MANT_W = 24;  // normalized mantissa width incl. hidden bit
    localparam int FP_EXP_W  = 8;   // biased exponent width
    localparam int FFO_IDX_W = 5;   // index width of the 24-bit leading-one finder

    // One sum offered by the add stage: carry+mantissa, guard/round/sticky, exponent.
    typedef struct packed {
        logic [FP_MANT_W:0]   mant;
        logic [2:0]           grs;
        logic [FP_EXP_W-1:0]  exp;
    } norm_in_t;

    // One normalized result with its status flags.
    typedef struct packed {
        logic [FP_MANT_W-1:0] mant;
        logic [FP_EXP_W-1:0]  exp;
        logic                 zero;
        logic                 ovf;
        logic                 unf;
    } norm_out_t;

endpackage

// File: rtl/normalize_stage_if.sv
// Upstream and downstream stream bundle of the normalize stage.
//
// Handshake (both directions): a transfer happens on a rising clk edge where
// valid and ready are both 1. While valid is 1 and ready is 0 the sender
// holds valid and all payload signals stable. ready never depends
// combinationally on valid of the same channel.
interface normalize_stage_if
    import fpadd_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W,
    parameter int EXP_W  = FP_EXP_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [MANT_W:0]   in_mant;
    logic [2:0]        in_grs;
    logic [EXP_W-1:0]  in_exp;

    logic              out_valid;
    logic              out_ready;
    logic [MANT_W-1:0] out_mant;
    logic [EXP_W-1:0]  out_exp;
    logic              out_zero;
    logic              out_ovf;
    logic              out_unf;

    // Seen from the normalize stage.
    modport slave (
        input  in_valid, in_mant, in_grs, in_exp, out_ready,
        output in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf
    );

    // Seen from the add stage / downstream consumer pair.
    modport master (
        output in_valid, in_mant, in_grs, in_exp, out_ready,
        input  in_ready, out_valid, out_mant, out_exp, out_zero, out_ovf, out_unf
    );

endinterface

// File: rtl/normalize_stage_ffo.sv
// FindFirstOne: priority encoder returning the index of the most
// significant set bit of a 24-bit vector.
module FindFirstOne
    import fpadd_pkg::*;
(
    input  logic [23:0]          vec,
    output logic                 valid,
    output logic [FFO_IDX_W-1:0] index
);

    // Ascending scan; the last hit (highest bit) wins.
    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int i = 0; i < 24; i++) begin
            if (vec[i]) begin
                valid = 1'b1;
                index = FFO_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/normalize_stage.sv
// normalize_stage: two-stage post-add normalizer with valid/ready backpressure.
// S1 registers the raw sum and finds its leading one; S2 shifts, adjusts the
// exponent, classifies zero/overflow/underflow and registers the result.
// Optional feature macro: NORMALIZE_ROUND_EN (round-to-nearest-even in S2);
// without it the mantissa is truncated.
module normalize_stage
    import fpadd_pkg::*;
#(
    parameter int MANT_W = FP_MANT_W,
    parameter int EXP_W  = FP_EXP_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    normalize_stage_if.slave        bus
);

    localparam int XW    = EXP_W + 2;           // signed exponent work width
    localparam int EXT_W = MANT_W + 3;          // mantissa with GRS appended
    localparam int SH_W  = $clog2(EXT_W);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;

    // Pipeline state
    logic      s1_valid;
    norm_in_t  s1_q;
    logic      s2_valid;
    norm_out_t s2_q;

    logic s1_adv;
    logic s2_adv;

    // Leading-one finder on the registered sum (carry excluded)
    logic                 ffo_valid;
    logic [FFO_IDX_W-1:0] ffo_idx;

    FindFirstOne u_ffo (
        .vec   (s1_q.mant[MANT_W-1:0]),
        .valid (ffo_valid),
        .index (ffo_idx)
    );

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_adv      = !s2_valid || bus.out_ready;
    assign s1_adv      = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // S2 datapath
    logic [EXT_W-1:0]        ext;
    logic [EXT_W-1:0]        ext_sh;
    logic [SH_W-1:0]         d;
    logic [MANT_W-1:0]       mant_sh;
    logic [MANT_W-1:0]       mant_fin;
    logic signed [XW-1:0]    exp_in;
    logic signed [XW-1:0]    exp_adj;
    logic signed [XW-1:0]    exp_fin;
    logic                    is_zero;
    norm_out_t               nxt;
`ifdef NORMALIZE_ROUND_EN
    logic [2:0]              grs_sh;
    logic                    round_up;
    logic [MANT_W:0]         mant_rnd;
`endif

    // Shift into 1.xxx form, adjust the exponent and classify the result.
    always_comb begin
        ext      = {s1_q.mant[MANT_W-1:0], s1_q.grs};
        ext_sh   = '0;
        d        = '0;
        mant_sh  = '0;
        mant_fin = '0;
        exp_in   = XW'(s1_q.exp);
        exp_adj  = exp_in;
        exp_fin  = exp_in;
        is_zero  = 1'b0;
        nxt      = '0;
`ifdef NORMALIZE_ROUND_EN
        grs_sh   = '0;
        round_up = 1'b0;
        mant_rnd = '0;
`endif
        if (s1_q.mant[MANT_W]) begin
            // Carry: one step right; dropped LSB becomes guard, old GRS go sticky.
            mant_sh = s1_q.mant[MANT_W:1];
            exp_adj = exp_in + XW'(1);
`ifdef NORMALIZE_ROUND_EN
            grs_sh  = {s1_q.mant[0], 1'b0, |s1_q.grs};
`endif
        end else begin
            // Left shift so the leading one lands in the hidden-bit position.
            // A leading one only inside GRS shifts past the whole mantissa.
            if (ffo_valid)          d = SH_W'(MANT_W - 1) - SH_W'(ffo_idx);
            else if (s1_q.grs[2])   d = SH_W'(MANT_W);
            else if (s1_q.grs[1])   d = SH_W'(MANT_W + 1);
            else if (s1_q.grs[0])   d = SH_W'(MANT_W + 2);
            else                    is_zero = 1'b1;
            ext_sh  = ext << d;
            mant_sh = MANT_W'(ext_sh >> 3);
            exp_adj = exp_in - XW'(d);
`ifdef NORMALIZE_ROUND_EN
            grs_sh  = ext_sh[2:0];
`endif
        end

`ifdef NORMALIZE_ROUND_EN
        // Round to nearest, ties to even; an all-ones carry-out renormalizes.
        round_up = grs_sh[2] && (grs_sh[1] || grs_sh[0] || mant_sh[0]);
        mant_rnd = {1'b0, mant_sh} + (MANT_W + 1)'(round_up);
        if (mant_rnd[MANT_W]) begin
            mant_fin = mant_rnd[MANT_W:1];
            exp_fin  = exp_adj + XW'(1);
        end else begin
            mant_fin = mant_rnd[MANT_W-1:0];
            exp_fin  = exp_adj;
        end
`else
        mant_fin = mant_sh;
        exp_fin  = exp_adj;
`endif

        if (is_zero) begin
            nxt.zero = 1'b1;
        end else if (exp_adj <= EXP_ZERO) begin
            nxt.zero = 1'b1;
            nxt.unf  = 1'b1;
        end else if (exp_fin >= EXP_MAX) begin
            nxt.exp  = '1;
            nxt.ovf  = 1'b1;
        end else begin
            nxt.mant = mant_fin;
            nxt.exp  = exp_fin[EXP_W-1:0];
        end
    end

    // Pipeline registers; each stage loads only when it may advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= '{mant: bus.in_mant, grs: bus.in_grs, exp: bus.in_exp};
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= nxt;
                end
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_mant  = s2_q.mant;
    assign bus.out_exp   = s2_q.exp;
    assign bus.out_zero  = s2_q.zero;
    assign bus.out_ovf   = s2_q.ovf;
    assign bus.out_unf   = s2_q.unf;

endmodule

// File: doc/normalize_stage.md
# normalize_stage

Pipelined post-add normalizer for the adder datapath. It takes the raw 25-bit mantissa sum (carry plus 24 bits) and the pre-add exponent from the add stage. It locates the leading one with the existing `FindFirstOne` priority encoder, shifts the mantissa into 1.xxx form and adjusts the exponent. It then flags zero, overflow and underflow, and delivers the result downstream over a valid/ready handshake with full backpressure.

## Interface
Parameters:
- MANT_W, 24, normalized mantissa width including hidden bit
- EXP_W, 8, biased exponent width; all-ones exponent means overflow/infinity

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream offers a sum
- in_ready  out  1  stage can accept this cycle
- in_mant  in  MANT_W+1  raw sum; bit MANT_W is the carry
- in_grs  in  3  guard/round/sticky bits below in_mant LSB
- in_exp  in  EXP_W  exponent before normalization
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_mant  out  MANT_W  normalized mantissa; bit MANT_W-1 is set unless zero/overflow
- out_exp  out  EXP_W  adjusted exponent
- out_zero, out_ovf, out_unf  out  1 each  result flags

## Operation
- Stage 1 (S1): registers the input, then drives `FindFirstOne` with in_mant[MANT_W-1:0] to get valid and index.
- Stage 2 (S2): performs the shift and exponent adjust, then registers the outputs.
- Shift amount:
  - Carry set: shift right 1, exponent +1. The dropped LSB becomes the new guard bit and the old GRS bits fold into sticky.
  - Carry clear, FFO valid with index k: shift left by d = MANT_W-1-k and fill from in_grs MSB-first, then zeros. Exponent -d.
  - Carry clear, FFO invalid, GRS zero: zero result. out_mant=0, out_exp=0, out_zero=1.
- Overflow: the adjusted exponent is ≥ 2^EXP_W-1. Output out_exp=all-ones, out_mant=0, out_ovf=1.
- Underflow: in_exp ≤ d (the exponent would be ≤ 0). Flush to out_mant=0, out_exp=0, out_unf=1, out_zero=1.
- Exponent arithmetic is done in EXP_W+2 bits signed to avoid wrap. Only one of ovf/unf can be set.

## Timing
- Latency: 2 cycles from an accepted input (in_valid & in_ready at edge N) to out_valid at edge N+2, with no stall.
- Throughput: 1 result per cycle.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv (combinational, no combinational path from in_valid)
- Output holding: out_* stay stable while out_valid & !out_ready.
- Simultaneous accept/deliver in the same cycle is allowed. No bubbles are inserted.
- Reset (rst_n low at an edge) clears s1_valid, s2_valid and all output registers to 0. In-flight data is discarded. in_ready reads 1 in the first cycle after reset.
- Reset asserted mid-stall drops all pending results. No output is produced from pre-reset inputs.

## Configuration
- NORMALIZE_ROUND_EN defined: S2 applies round-to-nearest-even using the post-shift GRS bits.
  - Mantissa overflow from rounding (all ones + 1) renormalizes: shift right 1, exponent +1, overflow rechecked.
  - Latency is unchanged.
- Undefined: truncation. The GRS bits only feed the shift fill and zero detection.

## Structure
- Package `fpadd_pkg`:
  - MANT_W and EXP_W default constants
  - typedef `norm_in_t` packed {mant, grs, exp}
  - typedef `norm_out_t` packed {mant, exp, zero, ovf, unf}
- One sub-module: `FindFirstOne` (24-bit input, valid, 5-bit index), instantiated once in S1.
- The shift/round logic stays inline.

## Test plan
- in_mant=25'h0800000, grs=0, exp=127 → after 2 cycles mant=24'h800000, exp=127, no flags.
- in_mant=25'h1000002, exp=127 → mant=24'h800001, exp=128. Input 25'h1000001 truncates to 24'h800000 without NORMALIZE_ROUND_EN; with it, a tie-to-even gives 24'h800000.
- in_mant=25'h0000001, exp=30 → mant=24'h800000, exp=7. Same input with exp=23 → zero, out_unf=1, out_zero=1.
- in_mant=25'h1FFFFFF, exp=254 → out_exp=8'hFF, mant=0, out_ovf=1. in_mant=0, grs=0 → out_zero=1, exp=0.
- Backpressure: offer 4 back-to-back inputs with out_ready=0 for 5 cycles → exactly 2 accepted, in_ready=0 afterwards, outputs stable. On release, all 4 appear in order with no loss or duplicates.
- Assert rst_n low for 1 cycle with 2 results in flight → out_valid=0 the next cycle, in_ready=1, and no stale result is ever emitted.
